// File: rtl/cfu_ram_line_buffer.sv
// Read-only single-line buffer between the CFU fetch master and the SoC Wishbone bus.
// Optional per-beat fill timeout is enabled by defining CFU_RAM_TIMEOUT_EN.
module cfu_ram_line_buffer #(
  parameter int unsigned LINE_WORDS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] up_adr,
  input  logic        up_cyc,
  input  logic        up_stb,
  input  logic        up_we,
  output logic [31:0] up_dat_miso,
  output logic        up_ack,
  output logic        up_err,
  output logic [29:0] dn_adr,
  output logic        dn_cyc,
  output logic        dn_stb,
  output logic        dn_we,
  output logic [3:0]  dn_sel,
  output logic [2:0]  dn_cti,
  output logic [1:0]  dn_bte,
  input  logic [31:0] dn_dat_miso,
  input  logic        dn_ack,
  input  logic        dn_err,
  input  logic        inv,
  output logic        stat_miss
);

  localparam int unsigned W    = $clog2(LINE_WORDS);
  localparam int unsigned TagW = 30 - W;

  typedef enum logic [1:0] {StIdle, StFill, StResp, StErr} state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic [W-1:0]    word_q, word_d;
  logic [W-1:0]    count_q, count_d;
  logic [29:0]     dn_adr_q, dn_adr_d;
  logic            dn_cyc_q, dn_cyc_d;
  logic            up_ack_q, up_ack_d;
  logic            up_err_q, up_err_d;
  logic            stat_miss_q, stat_miss_d;
  logic            live_q, live_d;          // requester has held up_cyc since acceptance
  logic            inv_seen_q, inv_seen_d;  // an invalidate landed while this fill was running
  logic [31:0]     line_q [LINE_WORDS];
  logic            line_we;

  logic            request;
  logic [TagW-1:0] req_tag;
  logic [W-1:0]    req_word;
  logic            hit;
  logic            last_beat;
  logic            timeout;

  assign request   = up_cyc & up_stb & ~up_ack_q & ~up_err_q;
  assign req_tag   = up_adr[29:W];
  assign req_word  = up_adr[W-1:0];
  assign hit       = valid_q & ~inv & (tag_q == req_tag);
  assign last_beat = (count_q == W'(LINE_WORDS - 1));

`ifdef CFU_RAM_TIMEOUT_EN
  logic [15:0] timer_q;

  // Counts idle clocks of the current beat; any ack or a fresh burst restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (!dn_cyc_q || dn_ack) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 16'd1;
    end
  end

  assign timeout = dn_cyc_q & ~dn_ack & ~dn_err & (timer_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    word_d      = word_q;
    count_d     = count_q;
    dn_adr_d    = dn_adr_q;
    dn_cyc_d    = dn_cyc_q;
    up_ack_d    = 1'b0;
    up_err_d    = 1'b0;
    stat_miss_d = 1'b0;
    live_d      = live_q;
    inv_seen_d  = inv_seen_q;
    line_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (request) begin
          if (up_we) begin
            state_d  = StErr;
            up_err_d = 1'b1;
          end else if (hit) begin
            up_ack_d = 1'b1;
            word_d   = req_word;
          end else begin
            state_d     = StFill;
            dn_adr_d    = {req_tag, {W{1'b0}}};
            dn_cyc_d    = 1'b1;
            count_d     = '0;
            stat_miss_d = 1'b1;
            valid_d     = 1'b0;
            tag_d       = req_tag;
            word_d      = req_word;
            live_d      = 1'b1;
            inv_seen_d  = 1'b0;
          end
        end
      end
      StFill: begin
        if (!up_cyc) live_d = 1'b0;
        if (inv) inv_seen_d = 1'b1;
        if (dn_err || timeout) begin
          dn_cyc_d = 1'b0;
          valid_d  = 1'b0;
          state_d  = StErr;
          // A master that walked away must not see a stray error termination.
          up_err_d = live_q & up_cyc;
        end else if (dn_ack) begin
          line_we  = 1'b1;
          count_d  = count_q + W'(1);
          dn_adr_d = dn_adr_q + 30'd1;
          if (last_beat) begin
            dn_cyc_d = 1'b0;
            valid_d  = ~(inv_seen_q | inv);
            state_d  = StResp;
            up_ack_d = live_q & up_cyc;
          end
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (inv) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      word_q      <= '0;
      count_q     <= '0;
      dn_adr_q    <= '0;
      dn_cyc_q    <= 1'b0;
      up_ack_q    <= 1'b0;
      up_err_q    <= 1'b0;
      stat_miss_q <= 1'b0;
      live_q      <= 1'b0;
      inv_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      word_q      <= word_d;
      count_q     <= count_d;
      dn_adr_q    <= dn_adr_d;
      dn_cyc_q    <= dn_cyc_d;
      up_ack_q    <= up_ack_d;
      up_err_q    <= up_err_d;
      stat_miss_q <= stat_miss_d;
      live_q      <= live_d;
      inv_seen_q  <= inv_seen_d;
    end
  end

  // Line data needs no reset; valid_q guards every read.
  always_ff @(posedge clk) begin
    if (line_we) line_q[count_q] <= dn_dat_miso;
  end

  assign up_ack      = up_ack_q;
  assign up_err      = up_err_q;
  assign up_dat_miso = up_ack_q ? line_q[word_q] : 32'h0;
  assign stat_miss   = stat_miss_q;

  assign dn_adr = dn_adr_q;
  assign dn_cyc = dn_cyc_q;
  assign dn_stb = dn_cyc_q;
  assign dn_we  = 1'b0;
  assign dn_sel = 4'b1111;
  assign dn_cti = dn_cyc_q ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign dn_bte = 2'b00;

endmodule

// File: tb/tb_cfu_ram_line_buffer.sv
// Directed self-checking bench for cfu_ram_line_buffer (LINE_WORDS=4, TIMEOUT_CYCLES=8).
module tb_cfu_ram_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] up_adr;
  logic        up_cyc, up_stb, up_we;
  logic [31:0] up_dat_miso;
  logic        up_ack, up_err;
  logic [29:0] dn_adr;
  logic        dn_cyc, dn_stb, dn_we;
  logic [3:0]  dn_sel;
  logic [2:0]  dn_cti;
  logic [1:0]  dn_bte;
  logic [31:0] dn_dat_miso;
  logic        dn_ack, dn_err, inv;
  logic        stat_miss;

  int total = 0;
  int bad   = 0;
  int miss_cnt = 0;

  cfu_ram_line_buffer #(
    .LINE_WORDS    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up_adr     (up_adr),
    .up_cyc     (up_cyc),
    .up_stb     (up_stb),
    .up_we      (up_we),
    .up_dat_miso(up_dat_miso),
    .up_ack     (up_ack),
    .up_err     (up_err),
    .dn_adr     (dn_adr),
    .dn_cyc     (dn_cyc),
    .dn_stb     (dn_stb),
    .dn_we      (dn_we),
    .dn_sel     (dn_sel),
    .dn_cti     (dn_cti),
    .dn_bte     (dn_bte),
    .dn_dat_miso(dn_dat_miso),
    .dn_ack     (dn_ack),
    .dn_err     (dn_err),
    .inv        (inv),
    .stat_miss  (stat_miss)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stat_miss === 1'b1) miss_cnt++;

  function automatic logic [31:0] mem(input logic [29:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_start(input logic [29:0] a);
    up_adr = a; up_cyc = 1'b1; up_stb = 1'b1; up_we = 1'b0;
    tick();
  endtask

  task automatic up_idle();
    up_cyc = 1'b0; up_stb = 1'b0; up_we = 1'b0;
    tick();
  endtask

  // Serves one burst; err_beat/inv_beat select the beat that errors or sees inv (-1: none).
  task automatic do_fill(input logic [29:0] base, input int err_beat, input int inv_beat);
    for (int b = 0; b < 4; b++) begin
      chk("fill dn_cyc", dn_cyc, 1);
      chk("fill dn_stb", dn_stb, 1);
      chk("fill dn_adr", dn_adr, base + 30'(b));
      chk("fill dn_cti", dn_cti, (b == 3) ? 32'd7 : 32'd2);
      dn_dat_miso = mem(base + 30'(b));
      if (b == err_beat) dn_err = 1'b1; else dn_ack = 1'b1;
      inv = (b == inv_beat);
      tick();
      dn_ack = 1'b0; dn_err = 1'b0; inv = 1'b0;
      if (b == err_beat) break;
    end
  endtask

  initial begin
    reset = 1'b0; up_adr = '0; up_cyc = 0; up_stb = 0; up_we = 0;
    dn_dat_miso = '0; dn_ack = 0; dn_err = 0; inv = 0;
    #3;
    chk("rst up_ack", up_ack, 0);
    chk("rst up_err", up_err, 0);
    chk("rst up_dat", up_dat_miso, 0);
    chk("rst dn_cyc", dn_cyc, 0);
    chk("rst dn_adr", dn_adr, 0);
    chk("rst dn_sel", dn_sel, 4'hf);
    chk("rst dn_cti", dn_cti, 0);
    chk("rst stat_miss", stat_miss, 0);
    tick();
    reset = 1'b1;
    tick();

    // 1: cold miss on 0x100
    rd_start(30'h100);
    chk("t1 stat_miss", stat_miss, 1);
    chk("t1 up_ack early", up_ack, 0);
    do_fill(30'h100, -1, -1);
    chk("t1 up_ack", up_ack, 1);
    chk("t1 up_dat", up_dat_miso, mem(30'h100));
    chk("t1 dn_cyc done", dn_cyc, 0);
    up_idle();
    chk("t1 ack one cycle", up_ack, 0);
    chk("t1 miss count", miss_cnt, 1);

    // 2: hit on 0x102
    rd_start(30'h102);
    chk("t2 up_ack", up_ack, 1);
    chk("t2 up_dat", up_dat_miso, mem(30'h102));
    chk("t2 dn_cyc", dn_cyc, 0);
    up_idle();

    // 3: other line, then back to the first
    rd_start(30'h105);
    chk("t3 miss a", dn_cyc, 1);
    do_fill(30'h104, -1, -1);
    chk("t3 up_dat a", up_dat_miso, mem(30'h105));
    up_idle();
    rd_start(30'h100);
    chk("t3 miss b", dn_cyc, 1);
    do_fill(30'h100, -1, -1);
    chk("t3 up_dat b", up_dat_miso, mem(30'h100));
    up_idle();
    chk("t3 miss count", miss_cnt, 3);

    // 4: bus error on beat index 2
    rd_start(30'h201);
    do_fill(30'h200, 2, -1);
    chk("t4 up_err", up_err, 1);
    chk("t4 up_ack", up_ack, 0);
    chk("t4 up_dat", up_dat_miso, 0);
    chk("t4 dn_cyc", dn_cyc, 0);
    up_idle();
    chk("t4 err one cycle", up_err, 0);
    rd_start(30'h201);
    do_fill(30'h200, -1, -1);
    chk("t4 refill ack", up_ack, 1);
    chk("t4 refill dat", up_dat_miso, mem(30'h201));
    up_idle();

    // 5: inv during third beat
    rd_start(30'h303);
    do_fill(30'h300, -1, 2);
    chk("t5 up_ack", up_ack, 1);
    chk("t5 up_dat", up_dat_miso, mem(30'h303));
    up_idle();
    rd_start(30'h301);
    chk("t5 miss after inv", dn_cyc, 1);
    do_fill(30'h300, -1, -1);
    chk("t5 up_dat refill", up_dat_miso, mem(30'h301));
    up_idle();
    // inv together with a would-be hit forces a miss
    up_adr = 30'h302; up_cyc = 1; up_stb = 1; inv = 1;
    tick();
    inv = 0;
    chk("t5 inv+hit miss", dn_cyc, 1);
    chk("t5 inv+hit no ack", up_ack, 0);
    do_fill(30'h300, -1, -1);
    chk("t5 inv+hit dat", up_dat_miso, mem(30'h302));
    up_idle();

    // 8: write request errors without bus traffic
    up_adr = 30'h300; up_cyc = 1; up_stb = 1; up_we = 1;
    tick();
    chk("t8 up_err", up_err, 1);
    chk("t8 up_ack", up_ack, 0);
    chk("t8 dn_cyc", dn_cyc, 0);
    up_idle();
    chk("t8 err one cycle", up_err, 0);
    chk("t8 dn_cyc after", dn_cyc, 0);
    rd_start(30'h300);
    chk("t8 line still valid", up_ack, 1);
    up_idle();

    // 6: reset mid-fill
    rd_start(30'h400);
    dn_ack = 1; dn_dat_miso = mem(30'h400);
    tick();
    dn_ack = 0;
    chk("t6 in fill", dn_cyc, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6 dn_cyc async", dn_cyc, 0);
    chk("t6 dn_stb async", dn_stb, 0);
    chk("t6 up_ack async", up_ack, 0);
    up_cyc = 0; up_stb = 0;
    tick();
    reset = 1'b1;
    tick();
    rd_start(30'h300);
    chk("t6 miss after reset", dn_cyc, 1);
    do_fill(30'h300, -1, -1);
    chk("t6 up_dat", up_dat_miso, mem(30'h300));
    up_idle();

    // 7: beat with no ack
    rd_start(30'h502);
    chk("t7 fill start", dn_cyc, 1);
`ifdef CFU_RAM_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("t7 no err before 8", up_err, 0);
    chk("t7 still filling", dn_cyc, 1);
    tick();
    chk("t7 up_err at 8", up_err, 1);
    chk("t7 dn_cyc dropped", dn_cyc, 0);
    chk("t7 no ack", up_ack, 0);
    up_idle();
`else
    for (int i = 0; i < 20; i++) tick();
    chk("t7 waits forever", dn_cyc, 1);
    chk("t7 no err", up_err, 0);
    do_fill(30'h500, -1, -1);
    chk("t7 late ack", up_ack, 1);
    chk("t7 late dat", up_dat_miso, mem(30'h502));
    up_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
